vend_credit_controller: RTL

- Parametrised successor to the per-item vending FSMs.
- One shared credit accumulator serves N_ITEMS products with per-item prices.
- Accepts nickel, dime and quarter coins, caps credit, supports cancel/refund and returns change as a train of nickel pulses.
- Sits between the coin acceptor front end and the dispense/change actuators.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_change_emitter.sv | 66 ++++++
 rtl/vend_credit_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared constants, state encoding and price helper for the
// vending credit controller.
//   NICKEL_C / DIME_C / QUARTER_C : coin values in cents
//   PRICES_MAX_W                  : widest packed price vector price_of accepts
//   state_t                       : controller states
//   price_of()                    : pull one price field out of a packed vector
package vend_pkg;

  localparam int unsigned NICKEL_C     = 5;
  localparam int unsigned DIME_C       = 10;
  localparam int unsigned QUARTER_C    = 25;
  localparam int unsigned PRICES_MAX_W = 256;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  // Price of item idx, where each field is w bits wide and item 0 sits in
  // the least significant field.
  function automatic logic [31:0] price_of(
    input logic [PRICES_MAX_W-1:0] prices,
    input int unsigned             idx,
    input int unsigned             w
  );
    logic [PRICES_MAX_W-1:0] shifted;
    logic [31:0]             mask;
    shifted = prices >> (idx * w);
    mask    = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/vend_change_emitter.sv
// vend_change_emitter: returns credit as a train of nickel pulses
// (one cycle high, one cycle low) and computes the down-counted credit.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   start         : begin a new train; the first pulse is registered on this edge
//   amount        : credit currently held (owned by the caller)
//   nickel_out    : registered pulse, one per 5 cents returned
//   done          : high in the cycle whose edge ends the train
//   remaining     : credit value the caller should register this cycle
module vend_change_emitter
  import vend_pkg::*;
#(
  parameter int PRICE_W = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [PRICE_W-1:0] amount,
  output logic               nickel_out,
  output logic               done,
  output logic [PRICE_W-1:0] remaining
);

  localparam logic [PRICE_W-1:0] STEP = PRICE_W'(NICKEL_C);

  logic active_reg, active_next;
  logic pulse_reg, pulse_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_reg <= 1'b0;
      pulse_reg  <= 1'b0;
    end else begin
      active_reg <= active_next;
      pulse_reg  <= pulse_next;
    end
  end

  // The decrement lands on the same edge that raises the pulse. The train
  // ends on the edge after the pulse that took the credit to zero, so there
  // is no trailing low cycle.
  always_comb begin
    active_next = active_reg;
    pulse_next  = 1'b0;
    remaining   = amount;
    done        = 1'b0;
    if (start) begin
      active_next = 1'b1;
      pulse_next  = 1'b1;
      remaining   = amount - STEP;
    end else if (active_reg) begin
      if (pulse_reg) begin
        if (amount == '0) begin
          done        = 1'b1;
          active_next = 1'b0;
        end
      end else begin
        pulse_next = 1'b1;
        remaining  = amount - STEP;
      end
    end
  end

  assign nickel_out = pulse_reg;

endmodule

// File: rtl/vend_credit_controller.sv
// vend_credit_controller: shared credit accumulator for N_ITEMS products.
// Accepts nickel/dime/quarter pulses, caps credit at CREDIT_MAX, vends a
// selected item when credit covers its price and returns change or a
// cancelled credit as nickel pulses.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   nickel_in/dime_in/quarter_in : single-cycle coin pulses
//   item_select           : one-hot product selection
//   cancel                : refund request
//   dispense              : one-cycle vend pulse
//   dispensed_item        : one-hot vended item while dispense=1, else 0
//   nickel_out            : one pulse per 5 cents returned
//   coin_reject           : a coin offered last cycle was not credited
//   credit                : current credit in cents
//   busy                  : vending or returning change
module vend_credit_controller
  import vend_pkg::*;
#(
  parameter int                         N_ITEMS    = 4,
  parameter int                         PRICE_W    = 7,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES     = {7'd35, 7'd30, 7'd25, 7'd15},
  parameter int                         CREDIT_MAX = 60
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               nickel_in,
  input  logic               dime_in,
  input  logic               quarter_in,
  input  logic [N_ITEMS-1:0] item_select,
  input  logic               cancel,
  output logic               dispense,
  output logic [N_ITEMS-1:0] dispensed_item,
  output logic               nickel_out,
  output logic               coin_reject,
  output logic [PRICE_W-1:0] credit,
  output logic               busy
);

  // Parameter sanity, rejected at elaboration.
  if (N_ITEMS * PRICE_W > PRICES_MAX_W) begin : g_bad_width
    $fatal(1, "PRICES vector is wider than price_of supports");
  end
  if ((CREDIT_MAX % 5) != 0 || CREDIT_MAX >= (2 ** PRICE_W)) begin : g_bad_cap
    $fatal(1, "CREDIT_MAX must be a multiple of 5 and fit in PRICE_W bits");
  end

  genvar gi;
  for (gi = 0; gi < N_ITEMS; gi++) begin : g_price_chk
    localparam int P = int'(PRICES[gi*PRICE_W +: PRICE_W]);
    if (P == 0 || (P % 5) != 0 || P > CREDIT_MAX) begin : g_bad_price
      $fatal(1, "item price must be nonzero, a multiple of 5 and <= CREDIT_MAX");
    end
  end

  localparam logic [PRICE_W:0]   CAP   = (PRICE_W+1)'(CREDIT_MAX);
  localparam logic [PRICE_W-1:0] VAL_N = PRICE_W'(NICKEL_C);
  localparam logic [PRICE_W-1:0] VAL_D = PRICE_W'(DIME_C);
  localparam logic [PRICE_W-1:0] VAL_Q = PRICE_W'(QUARTER_C);

  // Constant price table, one entry per item.
  logic [PRICE_W-1:0] price_tab [N_ITEMS];
  for (gi = 0; gi < N_ITEMS; gi++) begin : g_price_tab
    assign price_tab[gi] = PRICE_W'(price_of(PRICES_MAX_W'(PRICES), gi, PRICE_W));
  end

  state_t             state_reg, state_next;
  logic [PRICE_W-1:0] credit_reg, credit_next;
  logic               dispense_reg, dispense_next;
  logic [N_ITEMS-1:0] item_reg, item_next;
  logic               reject_reg, reject_next;
  logic               busy_reg, busy_next;

  logic [PRICE_W-1:0] sel_price;
  logic               sel_onehot;
  logic               coin_any;
  logic               coin_lower;
  logic [PRICE_W-1:0] coin_val;
  logic [PRICE_W:0]   coin_sum;
  logic               cancel_ok;
  logic               emit_start;
  logic               emit_done;
  logic [PRICE_W-1:0] emit_remaining;

  // Price of the selected item; only meaningful when the selection is one-hot.
  always_comb begin
    sel_price = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (item_select[i]) sel_price = sel_price | price_tab[i];
    end
  end

  assign sel_onehot = (item_select != '0) &&
                      ((item_select & (item_select - N_ITEMS'(1))) == '0);

  // Only the most valuable coin of a simultaneous group is considered;
  // any cheaper coin alongside it is rejected.
  assign coin_any   = nickel_in | dime_in | quarter_in;
  assign coin_lower = (quarter_in & (dime_in | nickel_in)) | (dime_in & nickel_in);
  assign coin_val   = quarter_in ? VAL_Q : (dime_in ? VAL_D : VAL_N);
  // One extra bit so the sum cannot wrap before the cap compare.
  assign coin_sum   = {1'b0, credit_reg} + {1'b0, coin_val};

  // Kept outside the next-state block so the emitter path has no apparent loop.
  assign cancel_ok  = (state_reg == COLLECT) && cancel && (credit_reg != '0);
  assign emit_start = cancel_ok || ((state_reg == DISPENSE) && (credit_reg != '0));

  vend_change_emitter #(
    .PRICE_W (PRICE_W)
  ) u_emitter (
    .clock      (clock),
    .reset      (reset),
    .start      (emit_start),
    .amount     (credit_reg),
    .nickel_out (nickel_out),
    .done       (emit_done),
    .remaining  (emit_remaining)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= COLLECT;
      credit_reg   <= '0;
      dispense_reg <= 1'b0;
      item_reg     <= '0;
      reject_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      credit_reg   <= credit_next;
      dispense_reg <= dispense_next;
      item_reg     <= item_next;
      reject_reg   <= reject_next;
      busy_reg     <= busy_next;
    end
  end

  // Outputs are registered from next-state values, so the dispense pulse
  // is shown together with the already-reduced credit.
  always_comb begin
    state_next    = state_reg;
    credit_next   = credit_reg;
    dispense_next = 1'b0;
    item_next     = '0;
    reject_next   = 1'b0;
    unique case (state_reg)
      COLLECT: begin
        if (cancel_ok) begin
          state_next  = CHANGE;
          credit_next = emit_remaining;
          reject_next = coin_any;
        end else if (sel_onehot && (credit_reg >= sel_price)) begin
          // Price is checked against the credit held before this cycle's coin.
          state_next    = DISPENSE;
          dispense_next = 1'b1;
          item_next     = item_select;
          credit_next   = credit_reg - sel_price;
          reject_next   = coin_any;
        end else if (coin_any) begin
          if (coin_sum <= CAP) begin
            credit_next = coin_sum[PRICE_W-1:0];
            reject_next = coin_lower;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      DISPENSE: begin
        reject_next = coin_any;
        if (credit_reg != '0) begin
          state_next  = CHANGE;
          credit_next = emit_remaining;
        end else begin
          state_next = COLLECT;
        end
      end
      CHANGE: begin
        reject_next = coin_any;
        credit_next = emit_remaining;
        if (emit_done) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  assign busy_next = (state_next != COLLECT);

  assign dispense       = dispense_reg;
  assign dispensed_item = item_reg;
  assign coin_reject    = reject_reg;
  assign credit         = credit_reg;
  assign busy           = busy_reg;

endmodule
